// File: rtl/demux_queue_pkg.sv
// Shared defaults and width helpers for the buffered 1-to-NOUT demultiplexer.
package demux_queue_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_NOUT  = 4;
   localparam int DEFAULT_DEPTH = 2;

   // A count spans 0..n inclusive, so it needs one bit more than a pointer.
   function automatic int count_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/demux_fifo.sv
// Single-channel synchronous FIFO; the head word is visible on rdata
// whenever the FIFO is not empty.
module demux_fifo
   import demux_queue_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == DEPTH_C);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_reg];

   // Simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
         count_next = count_reg - 1'b1;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         count_reg <= count_next;
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

endmodule

// File: rtl/demux_queue.sv
// Buffered 1-to-NOUT demultiplexer: one input stream fans out into
// independent per-channel FIFOs, each draining through its own port.
module demux_queue
   import demux_queue_pkg::*;
#(
   parameter int  WIDTH = DEFAULT_WIDTH,
   parameter int  NOUT  = DEFAULT_NOUT,
   parameter int  DEPTH = DEFAULT_DEPTH,
   localparam int SELW  = $clog2(NOUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SELW-1:0]       in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NOUT*WIDTH-1:0] out_data,
   output logic [NOUT-1:0]       out_valid,
   input  logic [NOUT-1:0]       out_ready,
   output logic                  err_sel
);

   localparam int NSEL = 1 << SELW;
   localparam logic [SELW:0] NOUT_C = (SELW + 1)'(NOUT);

   logic            in_range;
   logic [NSEL-1:0] full_pad;
   logic [NOUT-1:0] push_vec;
   logic [NOUT-1:0] empty_vec;
   logic            err_sel_reg;

   // Selector codes past NOUT are always accepted and then dropped.
   assign in_range = ({1'b0, in_sel} < NOUT_C);
   assign in_ready = in_range ? !full_pad[in_sel] : 1'b1;
   assign err_sel  = err_sel_reg;

   generate
      for (genvar gi = 0; gi < NOUT; gi++) begin : g_chan
         assign push_vec[gi]  = in_valid && in_range && (in_sel == SELW'(gi)) && !full_pad[gi];
         assign out_valid[gi] = !empty_vec[gi];

         demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_vec[gi]),
            .wdata (in_data),
            .pop   (out_ready[gi]),
            .rdata (out_data[gi*WIDTH +: WIDTH]),
            .full  (full_pad[gi]),
            .empty (empty_vec[gi])
         );
      end

      // Unused selector codes read as never full so the mux stays total.
      for (genvar gi = NOUT; gi < NSEL; gi++) begin : g_pad
         assign full_pad[gi] = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sel_reg <= 1'b0;
      end else begin
         err_sel_reg <= in_valid && !in_range;
      end
   end

endmodule

// File: tb/tb_demux_queue.sv
// Self-checking bench for demux_queue: directed scenarios plus a random
// run checked against per-channel queues.
module tb_demux_queue;

   localparam int WIDTH = 32;
   localparam int NOUT  = 4;
   localparam int DEPTH = 2;

   logic                  clk;
   logic                  rst;
   logic [WIDTH-1:0]      in_data;
   logic [1:0]            in_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic [NOUT*WIDTH-1:0] out_data;
   logic [NOUT-1:0]       out_valid;
   logic [NOUT-1:0]       out_ready;
   logic                  err_sel;

   logic [WIDTH-1:0]      b_in_data;
   logic [1:0]            b_in_sel;
   logic                  b_in_valid;
   logic                  b_in_ready;
   logic [3*WIDTH-1:0]    b_out_data;
   logic [2:0]            b_out_valid;
   logic [2:0]            b_out_ready;
   logic                  b_err_sel;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] q [NOUT][$];

   demux_queue #(.WIDTH(WIDTH), .NOUT(NOUT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel)
   );

   demux_queue #(.WIDTH(WIDTH), .NOUT(3), .DEPTH(DEPTH)) dut3 (
      .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .err_sel(b_err_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and update the reference queues from the
   // handshakes the specification defines on the pre-edge inputs.
   task automatic tick();
      bit            push;
      bit [NOUT-1:0] pops;
      push = in_valid && (q[in_sel].size() < DEPTH);
      for (int k = 0; k < NOUT; k++) begin
         pops[k] = out_ready[k] && (q[k].size() != 0);
      end
      @(posedge clk);
      for (int k = 0; k < NOUT; k++) begin
         if (pops[k]) void'(q[k].pop_front());
      end
      if (push) q[in_sel].push_back(in_data);
      #1;
   endtask

   function automatic logic [NOUT-1:0] exp_valid();
      logic [NOUT-1:0] v;
      for (int k = 0; k < NOUT; k++) v[k] = (q[k].size() != 0);
      return v;
   endfunction

   task automatic idle();
      in_valid    = 1'b0;
      in_sel      = '0;
      in_data     = '0;
      out_ready   = '0;
      b_in_valid  = 1'b0;
      b_in_sel    = '0;
      b_in_data   = '0;
      b_out_ready = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < NOUT; s++) begin
         in_sel = 2'(s);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
         end
      end
      n_checks++;
      if (out_valid !== 4'b0000 || err_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state out_valid=%b err_sel=%b exp 0000/0", out_valid, err_sel);
      end
      in_sel = '0;
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single();
      in_sel = 2'd2; in_data = 32'hA0; in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready got=%b exp=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0100 || out_data[2*WIDTH +: WIDTH] !== 32'hA0) begin
         n_fail++;
         $display("FAIL single_out valid=%b data=%h exp 0100/a0", out_valid, out_data[2*WIDTH +: WIDTH]);
      end
      out_ready = 4'b0100;
      tick();
      out_ready = '0;
      n_checks++;
      if (out_valid !== 4'b0000) begin
         n_fail++; $display("FAIL single_drain valid=%b exp=0000", out_valid);
      end
      $display("test_single done");
   endtask

   task automatic test_full_stall();
      logic [WIDTH-1:0] exp_w [2];
      exp_w[0] = 32'h1; exp_w[1] = 32'h2;
      out_ready = '0;
      in_valid = 1'b1; in_sel = 2'd1;
      in_data = 32'h1; tick();
      in_data = 32'h2; tick();
      in_data = 32'h9;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_ready_sel1 got=%b exp=0", in_ready);
      end
      tick();
      in_sel = 2'd0; in_data = 32'h3;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_ready_sel0 got=%b exp=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0011) begin
         n_fail++; $display("FAIL full_valid got=%b exp=0011", out_valid);
      end
      out_ready = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (out_valid[1] !== 1'b1 || out_data[WIDTH +: WIDTH] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL full_order idx=%0d valid=%b data=%h exp=%h", i, out_valid[1], out_data[WIDTH +: WIDTH], exp_w[i]);
         end
         tick();
      end
      n_checks++;
      if (out_valid !== 4'b0001 || out_data[WIDTH-1:0] !== 32'h3) begin
         n_fail++; $display("FAIL full_ch0 valid=%b data=%h exp 0001/3", out_valid, out_data[WIDTH-1:0]);
      end
      out_ready = 4'b0001;
      tick();
      out_ready = '0;
      $display("test_full_stall done");
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'd100;
      tick();
      out_ready = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'(101 + i);
         #1;
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 4'b1000 || out_data[3*WIDTH +: WIDTH] !== 32'(100 + i)) begin
            n_fail++;
            $display("FAIL b2b step=%0d ready=%b valid=%b data=%0d exp 1/1000/%0d", i, in_ready, out_valid, out_data[3*WIDTH +: WIDTH], 100 + i);
         end
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b1000 || out_data[3*WIDTH +: WIDTH] !== 32'd108) begin
         n_fail++; $display("FAIL b2b_last valid=%b data=%0d exp 1000/108", out_valid, out_data[3*WIDTH +: WIDTH]);
      end
      tick();
      out_ready = '0;
      n_checks++;
      if (out_valid !== 4'b0000) begin
         n_fail++; $display("FAIL b2b_empty valid=%b exp=0000", out_valid);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_bad_sel();
      b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 32'hDEAD;
      #1;
      n_checks++;
      if (b_in_ready !== 1'b1 || b_err_sel !== 1'b0) begin
         n_fail++; $display("FAIL badsel_pre ready=%b err=%b exp 1/0", b_in_ready, b_err_sel);
      end
      tick();
      b_in_valid = 1'b0;
      n_checks++;
      if (b_err_sel !== 1'b1 || b_out_valid !== 3'b000) begin
         n_fail++; $display("FAIL badsel_pulse err=%b valid=%b exp 1/000", b_err_sel, b_out_valid);
      end
      tick();
      n_checks++;
      if (b_err_sel !== 1'b0) begin
         n_fail++; $display("FAIL badsel_once err=%b exp=0", b_err_sel);
      end
      b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 32'h55;
      tick();
      b_in_valid = 1'b0;
      n_checks++;
      if (b_out_valid !== 3'b100 || b_out_data[2*WIDTH +: WIDTH] !== 32'h55 || b_err_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL badsel_good valid=%b data=%h err=%b exp 100/55/0", b_out_valid, b_out_data[2*WIDTH +: WIDTH], b_err_sel);
      end
      b_out_ready = 3'b100;
      tick();
      b_out_ready = '0;
      $display("test_bad_sel done");
   endtask

   task automatic test_reset_mid();
      out_ready = '0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_sel = (i < 2) ? 2'd0 : 2'd2;
         in_data = 32'(200 + i);
         tick();
      end
      in_sel = 2'd0;
      #1;
      n_checks++;
      if (out_valid !== 4'b0101 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_fill valid=%b ready=%b exp 0101/0", out_valid, in_ready);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_async valid=%b ready=%b exp 0000/1", out_valid, in_ready);
      end
      for (int k = 0; k < NOUT; k++) q[k].delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h77;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0001 || out_data[WIDTH-1:0] !== 32'h77) begin
         n_fail++; $display("FAIL rstmid_after valid=%b data=%h exp 0001/77", out_valid, out_data[WIDTH-1:0]);
      end
      out_ready = 4'b0001;
      tick();
      out_ready = '0;
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      int errs_before;
      errs_before = n_fail;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = 2'($urandom_range(0, NOUT - 1));
         in_data   = $urandom;
         out_ready = 4'($urandom);
         #1;
         n_checks++;
         if (in_ready !== (q[in_sel].size() < DEPTH)) begin
            n_fail++;
            $display("FAIL rand_ready cycle=%0d sel=%0d got=%b exp=%b", c, in_sel, in_ready, q[in_sel].size() < DEPTH);
         end
         n_checks++;
         if (out_valid !== exp_valid() || err_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_valid cycle=%0d got=%b exp=%b err=%b", c, out_valid, exp_valid(), err_sel);
         end
         for (int k = 0; k < NOUT; k++) begin
            if (q[k].size() != 0) begin
               n_checks++;
               if (out_data[k*WIDTH +: WIDTH] !== q[k][0]) begin
                  n_fail++;
                  $display("FAIL rand_data cycle=%0d ch=%0d got=%h exp=%h", c, k, out_data[k*WIDTH +: WIDTH], q[k][0]);
               end
            end
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = '1;
      repeat (DEPTH) tick();
      out_ready = '0;
      n_checks++;
      if (out_valid !== 4'b0000) begin
         n_fail++; $display("FAIL rand_drain valid=%b exp=0000", out_valid);
      end
      $display("test_random done, %0d new failures", n_fail - errs_before);
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_stall();
      test_back_to_back();
      test_bad_sel();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
